// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the program/data RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } arb_state_t;

    localparam logic [1:0] REQ_NONE = 2'd0;
    localparam logic [1:0] REQ_CPU  = 2'd1;
    localparam logic [1:0] REQ_DBG  = 2'd2;

    localparam int WAIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_wait_counter
// Brief    : Saturating count of cycles the debug port has been denied.
// Revision : 1.0 - initial release
// ============================================================================
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_limit
);

    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_max_wait)) begin
            r_cnt <= r_cnt + WAIT_W'(1);
        end
    end

    assign o_limit = (r_cnt == c_max_wait);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : CPU / debug arbiter for the single-port RAM with starvation
//            protection and locked debug bursts. Optional grant statistics
//            are enabled by defining ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       cpu_gnt_cnt,
    output logic [15:0]       dbg_gnt_cnt,
    output logic [7:0]        force_cnt
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [1:0]        w_owner;
    logic              w_wait_inc;
    logic              w_wait_clr;
    logic              w_wait_limit;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_wdata;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_wait_inc),
        .i_clear (w_wait_clr),
        .o_limit (w_wait_limit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner     = REQ_NONE;
        w_wait_inc  = 1'b0;
        w_wait_clr  = 1'b0;
        case (r_state)
            ARB: begin
                if (cpu_req && dbg_req) begin
                    if (w_wait_limit) begin
                        w_owner = REQ_DBG;
                    end else begin
                        w_owner    = REQ_CPU;
                        w_wait_inc = 1'b1;
                    end
                end else if (cpu_req) begin
                    w_owner = REQ_CPU;
                end else if (dbg_req) begin
                    w_owner = REQ_DBG;
                end
                if (!dbg_req || (w_owner == REQ_DBG)) begin
                    w_wait_clr = 1'b1;
                end
                if ((w_owner == REQ_DBG) && dbg_lock) begin
                    w_state_nxt = DBG_LOCK;
                end
            end
            DBG_LOCK: begin
                if (dbg_req) begin
                    w_owner = REQ_DBG;
                end
                w_wait_clr = 1'b1;
                if (!dbg_lock) begin
                    w_state_nxt = ARB;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are qualified by reset so nothing reaches the RAM while it is held.
    assign cpu_gnt   = reset && (w_owner == REQ_CPU);
    assign dbg_gnt   = reset && (w_owner == REQ_DBG);
    assign cpu_stall = reset && cpu_req && !cpu_gnt;
    assign mem_write = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);

    assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : r_last_addr);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : r_last_wdata);
    assign rdata     = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= cpu_gnt && !cpu_we;
            r_dbg_rvalid <= dbg_gnt && !dbg_we;
            if (cpu_gnt || dbg_gnt) begin
                r_last_addr  <= mem_addr;
                r_last_wdata <= mem_wdata;
            end
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;

`ifdef ARB_STATS_EN
    logic [15:0] r_cpu_gnt_cnt;
    logic [15:0] r_dbg_gnt_cnt;
    logic [7:0]  r_force_cnt;
    logic        w_force;

    // A force-grant is the debug win over a simultaneous CPU request.
    assign w_force = dbg_gnt && cpu_req && (r_state == ARB) && w_wait_limit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_gnt_cnt <= '0;
            r_dbg_gnt_cnt <= '0;
            r_force_cnt   <= '0;
        end else begin
            if (cpu_gnt && (r_cpu_gnt_cnt != 16'hFFFF)) begin
                r_cpu_gnt_cnt <= r_cpu_gnt_cnt + 16'd1;
            end
            if (dbg_gnt && (r_dbg_gnt_cnt != 16'hFFFF)) begin
                r_dbg_gnt_cnt <= r_dbg_gnt_cnt + 16'd1;
            end
            if (w_force && (r_force_cnt != 8'hFF)) begin
                r_force_cnt <= r_force_cnt + 8'd1;
            end
        end
    end

    assign cpu_gnt_cnt = r_cpu_gnt_cnt;
    assign dbg_gnt_cnt = r_dbg_gnt_cnt;
    assign force_cnt   = r_force_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a behavioural 1-cycle RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        int          cyc;
        logic        cg;
        logic        dg;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wd;
    } gnt_rec_t;

    typedef struct {
        int          cyc;
        logic        cpu;
        logic [15:0] data;
    } rv_rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic [15:0] mem_rdata;
    logic [15:0] rdata;
    logic        cpu_stall;
`ifdef ARB_STATS_EN
    logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt;
    logic [7:0]  force_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    gnt_rec_t gq[$];
    rv_rec_t  rq[$];

    logic [15:0] ram [0:255];
    logic        ram_ready = 1'b0;

    mem_arbiter #(.DATA_W(16), .ADDR_W(8), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_lock   (dbg_lock),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .rdata      (rdata),
        .cpu_stall  (cpu_stall)
`ifdef ARB_STATS_EN
        ,
        .cpu_gnt_cnt (cpu_gnt_cnt),
        .dbg_gnt_cnt (dbg_gnt_cnt),
        .force_cnt   (force_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM preloaded with 16'hA000 | addr on the first edge.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'hA000 | 16'(i);
            ram_ready <= 1'b1;
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cyc %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every grant and every rvalid against the scoreboard.
    always @(negedge clk) begin
        gnt_rec_t g;
        rv_rec_t  r;
        if (reset) begin
            if (cpu_gnt || dbg_gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {cpu_gnt, dbg_gnt}, 32'd0);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_cycle", cyc, g.cyc);
                    chk("gnt_who", {cpu_gnt, dbg_gnt}, {g.cg, g.dg});
                    chk("mem_write", mem_write, g.we);
                    chk("mem_addr", mem_addr, g.addr);
                    if (g.we) chk("mem_wdata", mem_wdata, g.wd);
                end
            end
            if (cpu_rvalid || dbg_rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", {cpu_rvalid, dbg_rvalid}, 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_cycle", cyc, r.cyc);
                    chk("rvalid_who", {cpu_rvalid, dbg_rvalid}, {r.cpu, !r.cpu});
                    chk("rdata", rdata, r.data);
                end
            end
        end
    end

    // owner: 0 none, 1 CPU, 2 debug. rv_exp pushes a read-data expectation.
    task automatic step(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                        input logic [15:0] c_wd, input logic d_req, input logic d_we,
                        input logic d_lock, input logic [7:0] d_addr, input logic [15:0] d_wd,
                        input int owner, input logic rv_exp, input logic [15:0] rv_data);
        gnt_rec_t g;
        rv_rec_t  r;
        @(posedge clk);
        #1;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dbg_req = d_req; dbg_we = d_we; dbg_lock = d_lock; dbg_addr = d_addr; dbg_wdata = d_wd;
        if (owner != 0) begin
            g.cyc  = cyc;
            g.cg   = (owner == 1);
            g.dg   = (owner == 2);
            g.we   = (owner == 1) ? c_we : d_we;
            g.addr = (owner == 1) ? c_addr : d_addr;
            g.wd   = (owner == 1) ? c_wd : d_wd;
            gq.push_back(g);
            if (rv_exp) begin
                r.cyc  = cyc + 1;
                r.cpu  = (owner == 1);
                r.data = rv_data;
                rq.push_back(r);
            end
        end
        @(negedge clk);
        chk("cpu_stall", cpu_stall, c_req && (owner != 1));
        if (owner == 0) chk("idle_no_gnt", {cpu_gnt, dbg_gnt, mem_write}, 32'd0);
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 16'h0);
    endtask

    initial begin
        // Reset held with a CPU read pending.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write, cpu_stall}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        step(1, 0, 8'h33, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 16'hA033);
        // Read aborted by reset before its data is consumed.
        step(1, 0, 8'h34, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 16'h0);
        @(posedge clk); #1 reset = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_read", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Starvation: both requesting, debug forced every 5th cycle.
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, 8'h80, 16'h1111, 1, 1, 0, 8'h81, 16'h2222,
                 ((k % 5) == 0) ? 2 : 1, 0, 16'h0);
        end
        idle();
`ifdef ARB_STATS_EN
        chk("cpu_gnt_cnt", cpu_gnt_cnt, 32'd16);
        chk("dbg_gnt_cnt", dbg_gnt_cnt, 32'd4);
        chk("force_cnt", force_cnt, 32'd4);
`endif

        // CPU write then read-back.
        step(1, 1, 8'h10, 16'hBEEF, 0, 0, 0, 8'h00, 16'h0, 1, 0, 16'h0);
        step(1, 0, 8'h10, 16'h0,    0, 0, 0, 8'h00, 16'h0, 1, 1, 16'hBEEF);
        idle();

        // Locked debug burst of 6 writes; CPU locked out until lock drops.
        step(0, 0, 8'h40, 16'h0, 1, 1, 1, 8'h00, 16'hD000, 2, 0, 16'h0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 8'h40, 16'h0, 1, 1, 1, 8'(i), 16'hD000 + 16'(i), 2, 0, 16'h0);
        end
        step(1, 0, 8'h40, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 16'h0);
        step(1, 0, 8'h40, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 16'hA040);
        step(1, 0, 8'h03, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 16'hD003);
        idle();

        // Debug locked read, then return to normal arbitration.
        step(0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h20, 16'h0, 2, 1, 16'hA020);
        step(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 16'h0);
        step(1, 0, 8'h21, 16'h0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 16'hA021);

        // dbg_lock without dbg_req must not lock the bus.
        step(1, 0, 8'h22, 16'h0, 0, 0, 1, 8'h00, 16'h0, 1, 1, 16'hA022);
        step(1, 0, 8'h23, 16'h0, 0, 0, 1, 8'h00, 16'h0, 1, 1, 16'hA023);
        idle();
        idle();

        chk("gnt_queue_drain", gq.size(), 32'd0);
        chk("rv_queue_drain", rq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
